// File: rtl/prga_arb_pktmux.sv
// Packet-level N:1 valid/ready mux with round-robin arbitration.
// A grant is held for a full packet and released on the last-beat handshake.
module prga_arb_pktmux #(
    parameter int NUM_SRC     = 4,
    parameter int INDEX_WIDTH = 2,
    parameter int DATA_WIDTH  = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_SRC-1:0]            src_val,
    output logic [NUM_SRC-1:0]            src_rdy,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
    input  logic [NUM_SRC-1:0]            src_last,
    output logic                          dst_val,
    input  logic                          dst_rdy,
    output logic [DATA_WIDTH-1:0]         dst_data,
    output logic                          dst_last,
    output logic [INDEX_WIDTH-1:0]        dst_src,
    output logic                          busy
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    typedef logic [INDEX_WIDTH-1:0] idx_t;

    logic [0:0] state_q, state_d;
    idx_t       grant_q, grant_d;
    idx_t       prio_q, prio_d;

    logic [DATA_WIDTH-1:0] data_arr [NUM_SRC];
    logic [NUM_SRC-1:0]    g_oh;
    logic                  locked;
    logic                  idle_found, re_found;
    idx_t                  idle_idx, re_idx, nxt_ptr;

    // Returns {found, index}; scan wraps at NUM_SRC, not at 2**INDEX_WIDTH.
    function automatic logic [INDEX_WIDTH:0] rr_pick(
        input logic [NUM_SRC-1:0] req,
        input idx_t               ptr
    );
        logic [2*NUM_SRC-1:0] rot;
        logic                 found;
        idx_t                 idx;
        int                   sum;
        rot   = {req, req} >> ptr;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (!found && rot[k]) begin
                found = 1'b1;
                sum   = int'(ptr) + k;
                if (sum >= NUM_SRC) sum = sum - NUM_SRC;
                idx   = idx_t'(sum);
            end
        end
        return {found, idx};
    endfunction

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_unpack
        assign data_arr[i] = src_data[i*DATA_WIDTH +: DATA_WIDTH];
    end

    always_comb begin
        g_oh          = '0;
        g_oh[grant_q] = 1'b1;
    end

    always_comb begin
        int np;
        np = int'(grant_q) + 1;
        if (np >= NUM_SRC) np = 0;
        nxt_ptr = idx_t'(np);
    end

    always_comb begin
        {idle_found, idle_idx} = rr_pick(src_val, prio_q);
        {re_found, re_idx}     = rr_pick(src_val & ~g_oh, nxt_ptr);
    end

    assign locked   = (state_q == ST_LOCKED);
    assign busy     = locked;
    assign dst_src  = grant_q;
    assign dst_val  = locked & src_val[grant_q];
    assign dst_last = dst_val & src_last[grant_q];
    assign dst_data = dst_val ? data_arr[grant_q] : '0;
    assign src_rdy  = locked ? (g_oh & {NUM_SRC{dst_rdy}}) : '0;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        prio_d  = prio_q;
        case (state_q)
            ST_IDLE: begin
                if (idle_found) begin
                    state_d = ST_LOCKED;
                    grant_d = idle_idx;
                end
            end
            ST_LOCKED: begin
                // Last beat: rotate priority past the owner, hand over with no bubble.
                if (dst_val && dst_rdy && dst_last) begin
                    prio_d = nxt_ptr;
                    if (re_found) grant_d = re_idx;
                    else          state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            prio_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            prio_q  <= prio_d;
        end
    end

endmodule

// File: tb/tb_prga_arb_pktmux.sv
// Bench for prga_arb_pktmux: cycle table for arbitration/fairness plus
// hand sequences for lock, stall/bubble and mid-packet reset.
module tb_prga_arb_pktmux;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  src_val, src_rdy, src_last;
    logic [127:0] src_data;
    logic        dst_val, dst_rdy, dst_last, busy;
    logic [31:0] dst_data;
    logic [1:0]  dst_src;
    logic [31:0] d [4];

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [1:0]  src;
        logic [31:0] data;
        logic        last;
    } beat_t;

    typedef struct {
        logic       rst;
        logic [3:0] val;
        logic [3:0] last;
        logic       rdy;
        logic       busy;
        logic [1:0] src;
        logic       dval;
        logic [3:0] srdy;
    } row_t;

    beat_t sb_q[$];
    row_t  tbl [16];

    always #5 clk = ~clk;

    assign src_data = {d[3], d[2], d[1], d[0]};

    prga_arb_pktmux #(
        .NUM_SRC(4), .INDEX_WIDTH(2), .DATA_WIDTH(32)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .src_val(src_val), .src_rdy(src_rdy),
        .src_data(src_data), .src_last(src_last),
        .dst_val(dst_val), .dst_rdy(dst_rdy),
        .dst_data(dst_data), .dst_last(dst_last),
        .dst_src(dst_src), .busy(busy)
    );

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic push(input logic [1:0] s, input logic [31:0] dd, input logic l);
        beat_t b;
        b.src  = s;
        b.data = dd;
        b.last = l;
        sb_q.push_back(b);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic rst_seq();
        rst_n   = 1'b0;
        src_val = '0;
        dst_rdy = 1'b0;
        cyc();
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin : mon
        beat_t e;
        if (rst_n && dst_val && dst_rdy) begin
            checks++;
            if (sb_q.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected got src=%0d data=%h last=%0d",
                         dst_src, dst_data, dst_last);
            end else begin
                e = sb_q.pop_front();
                if (dst_src !== e.src || dst_data !== e.data || dst_last !== e.last) begin
                    failures++;
                    $display("FAIL sb_beat got src=%0d data=%h last=%0d exp src=%0d data=%h last=%0d",
                             dst_src, dst_data, dst_last, e.src, e.data, e.last);
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 4; i++) d[i] = 32'hD0 + i;
        rst_n = 1'b0; src_val = '0; src_last = '0; dst_rdy = 1'b0;

        // rst, val, last, rdy | busy, src, dval, srdy
        tbl[0]  = '{1'b0, 4'b1111, 4'b1111, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0000};
        tbl[1]  = '{1'b0, 4'b1111, 4'b1111, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0000};
        tbl[2]  = '{1'b1, 4'b1010, 4'b1010, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0000};
        tbl[3]  = '{1'b1, 4'b1010, 4'b1010, 1'b1, 1'b1, 2'd1, 1'b1, 4'b0010};
        tbl[4]  = '{1'b1, 4'b1000, 4'b1000, 1'b1, 1'b1, 2'd3, 1'b1, 4'b1000};
        tbl[5]  = '{1'b1, 4'b0000, 4'b0000, 1'b1, 1'b0, 2'd3, 1'b0, 4'b0000};
        tbl[6]  = '{1'b1, 4'b1111, 4'b1111, 1'b1, 1'b0, 2'd3, 1'b0, 4'b0000};
        tbl[7]  = '{1'b1, 4'b1111, 4'b1111, 1'b1, 1'b1, 2'd0, 1'b1, 4'b0001};
        tbl[8]  = '{1'b1, 4'b1111, 4'b1111, 1'b1, 1'b1, 2'd1, 1'b1, 4'b0010};
        tbl[9]  = '{1'b1, 4'b1111, 4'b1111, 1'b1, 1'b1, 2'd2, 1'b1, 4'b0100};
        tbl[10] = '{1'b1, 4'b1111, 4'b1111, 1'b1, 1'b1, 2'd3, 1'b1, 4'b1000};
        tbl[11] = '{1'b1, 4'b1111, 4'b1111, 1'b1, 1'b1, 2'd0, 1'b1, 4'b0001};
        tbl[12] = '{1'b1, 4'b1111, 4'b1111, 1'b1, 1'b1, 2'd1, 1'b1, 4'b0010};
        tbl[13] = '{1'b1, 4'b0000, 4'b0000, 1'b1, 1'b1, 2'd2, 1'b0, 4'b0100};
        tbl[14] = '{1'b1, 4'b0100, 4'b0100, 1'b1, 1'b1, 2'd2, 1'b1, 4'b0100};
        tbl[15] = '{1'b1, 4'b0000, 4'b0000, 1'b1, 1'b0, 2'd2, 1'b0, 4'b0000};

        cyc();
        for (int r = 0; r < 16; r++) begin
            rst_n    = tbl[r].rst;
            src_val  = tbl[r].val;
            src_last = tbl[r].last;
            dst_rdy  = tbl[r].rdy;
            #2;
            chk($sformatf("row%0d_busy", r), busy, tbl[r].busy);
            chk($sformatf("row%0d_src", r), dst_src, tbl[r].src);
            chk($sformatf("row%0d_dval", r), dst_val, tbl[r].dval);
            chk($sformatf("row%0d_srdy", r), src_rdy, tbl[r].srdy);
            chk($sformatf("row%0d_data", r), dst_data,
                tbl[r].dval ? 32'hD0 + tbl[r].src : 32'h0);
            if (tbl[r].rst && tbl[r].dval && tbl[r].rdy)
                push(tbl[r].src, 32'hD0 + tbl[r].src, tbl[r].last[tbl[r].src]);
            cyc();
        end

        // Lock: src0 three-beat packet while src2 waits.
        rst_seq();
        d[0] = 32'hA0; d[2] = 32'hC0;
        src_last = 4'b0100; src_val = 4'b0101; dst_rdy = 1'b1;
        #2 chk("lk_idle_busy", busy, 0);
        cyc();
        #2 chk("lk_a0", dst_data, 32'hA0);
        chk("lk_rdy0", src_rdy, 4'b0001);
        push(0, 32'hA0, 0);
        cyc();
        d[0] = 32'hA1;
        #2 chk("lk_a1", dst_data, 32'hA1);
        chk("lk_rdy1", src_rdy, 4'b0001);
        push(0, 32'hA1, 0);
        cyc();
        d[0] = 32'hA2; src_last = 4'b0101;
        #2 chk("lk_a2", dst_data, 32'hA2);
        chk("lk_a2_last", dst_last, 1);
        push(0, 32'hA2, 1);
        cyc();
        src_val = 4'b0100; src_last = 4'b0100;
        #2 chk("lk_handover", dst_src, 2);
        chk("lk_c0", dst_data, 32'hC0);
        push(2, 32'hC0, 1);
        cyc();
        src_val = '0;
        #2 chk("lk_end_busy", busy, 0);

        // Stall then source bubble on src1.
        rst_seq();
        d[1] = 32'hB0; src_val = 4'b0010; src_last = '0; dst_rdy = 1'b1;
        #2 chk("st_idle", busy, 0);
        cyc();
        #2 chk("st_b0", dst_data, 32'hB0);
        push(1, 32'hB0, 0);
        cyc();
        d[1] = 32'hB1; dst_rdy = 1'b0;
        repeat (3) begin
            #2 chk("st_hold", dst_data, 32'hB1);
            chk("st_busy", busy, 1);
            chk("st_rdy", src_rdy, 4'b0000);
            cyc();
        end
        dst_rdy = 1'b1;
        #2 chk("st_b1", dst_data, 32'hB1);
        push(1, 32'hB1, 0);
        cyc();
        src_val = '0;
        repeat (2) begin
            #2 chk("bub_dval", dst_val, 0);
            chk("bub_busy", busy, 1);
            chk("bub_data", dst_data, 0);
            cyc();
        end
        d[1] = 32'hB2; src_val = 4'b0010;
        #2 chk("st_b2", dst_val, 1);
        push(1, 32'hB2, 0);
        cyc();
        d[1] = 32'hB3; src_last = 4'b0010;
        #2 chk("st_b3_last", dst_last, 1);
        push(1, 32'hB3, 1);
        cyc();
        src_val = '0; src_last = '0;
        #2 chk("st_end_busy", busy, 0);

        // Reset in the middle of a src3 packet.
        rst_seq();
        d[3] = 32'hE0; src_val = 4'b1000; src_last = '0; dst_rdy = 1'b1;
        #2 chk("mr_idle", busy, 0);
        cyc();
        #2 chk("mr_src3", dst_src, 3);
        push(3, 32'hE0, 0);
        cyc();
        d[3] = 32'hE1;
        #2 push(3, 32'hE1, 0);
        cyc();
        d[3] = 32'hE2; d[0] = 32'hF0;
        rst_n = 1'b0; dst_rdy = 1'b0; src_val = 4'b1001;
        cyc();
        rst_n = 1'b1; dst_rdy = 1'b1; src_last = 4'b0001;
        #2 chk("mr_busy0", busy, 0);
        chk("mr_src0", dst_src, 0);
        chk("mr_dval0", dst_val, 0);
        cyc();
        src_val = 4'b0001;
        #2 chk("mr_regrant_busy", busy, 1);
        chk("mr_regrant_src", dst_src, 0);
        push(0, 32'hF0, 1);
        cyc();
        src_val = '0; src_last = '0;
        #2 chk("mr_end_busy", busy, 0);
        cyc();

        chk("sb_drain", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
